serial_add_ctrl: RTL and testbench

- Bit-serial adder/subtractor controller.
- Sequences a single 1-bit full-adder cell over WIDTH cycles, LSB first, to add or subtract two WIDTH-bit operands.
- Owns operand capture, the carry register, the bit counter, result assembly and the start/busy/done handshake.
- Sits between a requesting datapath and the shared 1-bit full-adder cell. Trades area for latency.

---
 rtl/serial_add_ctrl_pkg.sv | 5 +
 rtl/serial_add_ctrl_if.sv | 14 +
 rtl/serial_add_ctrl_fa_cell.sv | 11 +
 rtl/serial_add_ctrl.sv | 55 +++++
 tb/tb_serial_add_ctrl.sv | 120 ++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_arith_pkg: shared state encoding and constants for the bit-serial adder controller.
package serial_arith_pkg;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   localparam logic SUB_CIN = 1'b1;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/response bundle between a requesting datapath and the serial adder.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   modport master (output start, sub, cin, a, b, input busy, done, sum, cout);
   modport slave (input start, sub, cin, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder shared by the serial controller.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell LSB-first over WIDTH cycles to add or subtract.
module serial_add_ctrl import serial_arith_pkg::*; #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input logic clk,
   input logic rst,
   serial_add_ctrl_if.slave bus
);
   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, res, sum_q;
   logic [CNT_W-1:0] cnt;
   logic             carry, cout_q, s, co, last;
   fa_cell u_fa (.a(sa[0]), .b(sb[0]), .ci(carry), .s(s), .co(co));
   assign last     = cnt == CNT_W'(WIDTH - 1);
   assign bus.busy = state == S_RUN;
   assign bus.done = state == S_DONE;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state == S_IDLE ? (bus.start ? S_RUN : S_IDLE) :
                 state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
   end
   // Final bit lands in sum/cout on the last RUN edge so both are valid during DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
      end else if (state == S_IDLE && bus.start) begin
         sa    <= bus.a;
         sb    <= bus.sub ? ~bus.b : bus.b;
         carry <= bus.sub ? SUB_CIN : bus.cin;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         res   <= {s, res[WIDTH-1:1]};
         carry <= co;
         cnt   <= cnt + CNT_W'(1);
         if (last) begin
            sum_q  <= {s, res[WIDTH-1:1]};
            cout_q <= co;
         end
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomised checks of serial_add_ctrl against plain arithmetic.
module tb_serial_add_ctrl;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passes = 0;
   int   fails = 0;
   serial_add_ctrl_if #(.WIDTH(W)) bus ();
   serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic scramble();
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      bus.sub = 1'($urandom);
   endtask
   // Issues one request from IDLE, checks latency and result, then returns to IDLE.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv, input logic sv);
      logic [W:0] exp_v;
      int n;
      exp_v = sv ? {av >= bv, W'(av - bv)} : {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
      bus.a = av;
      bus.b = bv;
      bus.cin = cv;
      bus.sub = sv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      scramble();
      n = 1;
      while (!bus.done && n < 3 * W) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, 64'(n), 64'(W + 1));
      chk({tag, " sum"}, 64'(bus.sum), 64'(exp_v[W-1:0]));
      chk({tag, " cout"}, 64'(bus.cout), 64'(exp_v[W]));
      tick();
   endtask
   initial begin
      int n;
      int dones;
      bus.start = 1'b0;
      scramble();
      tick();
      tick();
      rst = 1'b0;
      chk("reset", {60'd0, bus.busy, bus.done, bus.cout, 1'b0} | 64'(bus.sum), 64'd0);
      bus.a = 8'h3C; bus.b = 8'h45; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      scramble();
      for (int c = 1; c <= W; c++) begin
         chk($sformatf("t1 busy c%0d", c), {62'd0, bus.busy, bus.done}, 64'b10);
         tick();
      end
      chk("t1 done", {62'd0, bus.busy, bus.done}, 64'b01);
      chk("t1 sum", 64'(bus.sum), 64'h81);
      chk("t1 cout", 64'(bus.cout), 64'd0);
      tick();
      chk("t1 idle", {62'd0, bus.busy, bus.done}, 64'b00);
      run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0);
      run_op("ff+00+c", 8'hFF, 8'h00, 1'b1, 1'b0);
      run_op("10-01", 8'h10, 8'h01, 1'b1, 1'b1);
      chk("10-01 const", {55'd0, bus.cout, bus.sum}, {55'd0, 1'b1, 8'h0F});
      run_op("01-02", 8'h01, 8'h02, 1'b0, 1'b1);
      chk("01-02 const", {55'd0, bus.cout, bus.sum}, {55'd0, 1'b0, 8'hFF});
      bus.a = 8'h0A; bus.b = 8'h05; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      bus.a = 8'h77; bus.b = 8'h11; bus.sub = 1'b1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 5;
      while (!bus.done && n < 3 * W) begin
         tick();
         n++;
      end
      chk("ignore latency", 64'(n), 64'(W + 1));
      chk("ignore sum", {55'd0, bus.cout, bus.sum}, {55'd0, 1'b0, 8'h0F});
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("hold %0d", i), {55'd0, bus.done, bus.sum}, {55'd0, 1'b0, 8'h0F});
      end
      bus.a = 8'h5A; bus.b = 8'h33; bus.cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid rst", {53'd0, bus.busy, bus.done, bus.cout, bus.sum}, 64'd0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         dones += int'(bus.done | bus.busy);
      end
      chk("no done after rst", 64'(dones), 64'd0);
      run_op("post rst", 8'h5A, 8'h33, 1'b1, 1'b0);
      for (int i = 0; i < 1000; i++)
         run_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
